// File: rtl/fft_pkg.sv
// Shared FFT definitions: constant log2, coefficient scaling
// and quadrant encoding used by the twiddle generator.
package fft_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r++;
    end
    return r;
  endfunction

  localparam int COEF_W_DEF = 9;
  localparam int COEF_ONE   = 1 << (COEF_W_DEF - 2);

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

endpackage

// File: rtl/twiddle_qrom.sv
// Quarter-wave cosine ROM: addr m -> round(2^(COEF_W-2)*cos(2*pi*m/N)).
// Tables are script-generated per (N_POINTS, COEF_W) pair.
module twiddle_qrom
  import fft_pkg::*;
#(
  parameter int N_POINTS = 32,
  parameter int COEF_W   = 9,
  localparam int AW      = clog2(N_POINTS) - 1
) (
  input  logic        [AW-1:0]     addr,
  output logic signed [COEF_W-1:0] cos_o
);

  generate
    if (N_POINTS == 32 && COEF_W == 9) begin : g_n32_w9
      always_comb begin
        cos_o = '0;
        case (addr)
          4'd0:    cos_o = 9'(COEF_ONE);
          4'd1:    cos_o = 9'sd126;
          4'd2:    cos_o = 9'sd118;
          4'd3:    cos_o = 9'sd106;
          4'd4:    cos_o = 9'sd91;
          4'd5:    cos_o = 9'sd71;
          4'd6:    cos_o = 9'sd49;
          4'd7:    cos_o = 9'sd25;
          default: cos_o = 9'sd0;
        endcase
      end
    end else if (N_POINTS == 8 && COEF_W == 9) begin : g_n8_w9
      always_comb begin
        cos_o = '0;
        case (addr)
          2'd0:    cos_o = 9'(COEF_ONE);
          2'd1:    cos_o = 9'sd91;
          default: cos_o = 9'sd0;
        endcase
      end
    end else begin : g_bad
      $fatal(1, "twiddle_qrom: no table for this N_POINTS/COEF_W");
    end
  endgenerate

endmodule

// File: rtl/twiddle_gen.sv
// Per-stage twiddle generator for a radix-2 DIF MDC FFT.
// Counter -> exponent/quadrant fold -> quarter-wave ROM, 2-cycle latency.
module twiddle_gen
  import fft_pkg::*;
#(
  parameter int N_POINTS = 32,
  parameter int COEF_W   = 9,
  parameter int STAGE    = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sync,
  input  logic                     in_valid,
  output logic signed [COEF_W-1:0] w_r,
  output logic signed [COEF_W-1:0] w_i,
  output logic                     out_valid
);

  localparam int LG   = clog2(N_POINTS);
  localparam int CW   = LG - 1;
  localparam int MW   = LG - 2;
  localparam int SPAN = N_POINTS >> (STAGE + 1);
  localparam logic [CW-1:0] KMASK = CW'(SPAN - 1);
  localparam logic [CW-1:0] QTR   = CW'(N_POINTS / 4);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] k, e;
  logic [MW-1:0] m_q, m_d;
  logic [1:0]    q_q, q_d;
  logic          v1_q, v1_d;
  logic          v2_q, v2_d;
  logic signed [COEF_W-1:0] wr_q, wr_d;
  logic signed [COEF_W-1:0] wi_q, wi_d;

  logic [CW-1:0] c_addr, s_addr;
  logic signed [COEF_W-1:0] c_val, s_val;

  always_comb begin
    k     = sync ? '0 : cnt_q;
    cnt_d = in_valid ? k + CW'(1) : k;
    // Last stage has SPAN=1, so the mask forces e=0.
    e     = (k & KMASK) << STAGE;
    q_d   = 2'(e >> MW);
    m_d   = e[MW-1:0];
    v1_d  = in_valid;
  end

  assign c_addr = {1'b0, m_q};
  assign s_addr = QTR - c_addr;

  twiddle_qrom #(
    .N_POINTS(N_POINTS),
    .COEF_W  (COEF_W)
  ) u_rom_c (
    .addr (c_addr),
    .cos_o(c_val)
  );

  twiddle_qrom #(
    .N_POINTS(N_POINTS),
    .COEF_W  (COEF_W)
  ) u_rom_s (
    .addr (s_addr),
    .cos_o(s_val)
  );

  always_comb begin
    wr_d = wr_q;
    wi_d = wi_q;
    v2_d = v1_q;
    if (v1_q) begin
      unique case (1'b1)
        (q_q == Q0): begin wr_d = c_val;  wi_d = -s_val; end
        (q_q == Q1): begin wr_d = -s_val; wi_d = -c_val; end
        (q_q == Q2): begin wr_d = -c_val; wi_d = s_val;  end
        (q_q == Q3): begin wr_d = s_val;  wi_d = c_val;  end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      m_q   <= '0;
      q_q   <= Q0;
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      wr_q  <= '0;
      wi_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      m_q   <= m_d;
      q_q   <= q_d;
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      wr_q  <= wr_d;
      wi_q  <= wi_d;
    end
  end

  assign w_r       = wr_q;
  assign w_i       = wi_q;
  assign out_valid = v2_q;

endmodule
